// File: rtl/wash_pkg.sv
// Shared types for the wash-machine phase timer: timer state encoding and
// the duration-select codes driven by the controller FSM.
package wash_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        PAUSE = 2'd2,
        PULSE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        NUM_NONE = 2'b00,
        NUM_SOAK = 2'b01,
        NUM_MID  = 2'b10,
        NUM_WASH = 2'b11
    } num_e;

    function automatic logic in_phase(input state_e s);
        return (s == COUNT) || (s == PAUSE);
    endfunction

endpackage

// File: rtl/wash_pulse_gen.sv
// Turns a one-cycle start strobe into a contiguous PULSE_WIDTH-cycle pulse and
// flags the last pulse cycle with done_o.
module wash_pulse_gen
    import wash_pkg::*;
#(
    parameter int unsigned PULSE_WIDTH = 10,
    parameter int unsigned PW_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic pulse_o,
    output logic done_o
);

    localparam logic [PW_W-1:0] PW_LAST = PW_W'(PULSE_WIDTH - 1);
    localparam logic [PW_W-1:0] PW_ONE  = PW_W'(1);

    logic            pulse_q, pulse_d;
    logic [PW_W-1:0] pw_q, pw_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= 1'b0;
            pw_q    <= '0;
        end else begin
            pulse_q <= pulse_d;
            pw_q    <= pw_d;
        end
    end

    always_comb begin
        pulse_d = pulse_q;
        pw_d    = pw_q;
        done_o  = pulse_q && (pw_q == PW_LAST);
        if (start_i) begin
            pulse_d = 1'b1;
            pw_d    = '0;
        end else if (pulse_q) begin
            if (pw_q == PW_LAST) begin
                pulse_d = 1'b0;
                pw_d    = '0;
            end else begin
                pw_d = pw_q + PW_ONE;
            end
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/wash_phase_timer.sv
// Phase-duration timer feeding the wash controller's pulse input: counts enabled
// cycles for the selected phase, freezes while paused, then emits a fixed pulse.
module wash_phase_timer
    import wash_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned T_SOAK      = 60,
    parameter int unsigned T_MID       = 120,
    parameter int unsigned T_WASH      = 180,
    parameter int unsigned PULSE_WIDTH = 10,
    parameter int unsigned PW_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_CntEN,
    input  logic [1:0]       i_CntNUM,
    output logic             o_cntPulse,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_remaining
);

    localparam logic [CNT_W-1:0] TGT_SOAK = CNT_W'(T_SOAK);
    localparam logic [CNT_W-1:0] TGT_MID  = CNT_W'(T_MID);
    localparam logic [CNT_W-1:0] TGT_WASH = CNT_W'(T_WASH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] sel_target;
    logic             pg_start;
    logic             pg_pulse;
    logic             pg_done;

    always_comb begin
        sel_target = '0;
        case (i_CntNUM)
            NUM_SOAK: sel_target = TGT_SOAK;
            NUM_MID:  sel_target = TGT_MID;
            NUM_WASH: sel_target = TGT_WASH;
            default:  sel_target = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

    // COUNT and PAUSE share one branch: an enabled cycle counts whether or not
    // the previous cycle was paused, so resuming loses no time.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        pg_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_CntEN && (i_CntNUM != NUM_NONE)) begin
                    target_d = sel_target;
                    cnt_d    = '0;
                    state_d  = COUNT;
                end
            end
            COUNT, PAUSE: begin
                if (!i_CntEN) begin
                    state_d = PAUSE;
                end else if (cnt_q == (target_q - CNT_ONE)) begin
                    cnt_d    = '0;
                    pg_start = 1'b1;
                    state_d  = PULSE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = COUNT;
                end
            end
            PULSE: begin
                if (pg_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    wash_pulse_gen #(
        .PULSE_WIDTH(PULSE_WIDTH),
        .PW_W       (PW_W)
    ) u_pulse_gen (
        .clk    (clk),
        .rst    (rst),
        .start_i(pg_start),
        .pulse_o(pg_pulse),
        .done_o (pg_done)
    );

    assign o_cntPulse  = pg_pulse;
    assign o_busy      = (state_q != IDLE);
    assign o_remaining = in_phase(state_q) ? (target_q - cnt_q) : '0;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer: expected pulse windows are queued as each
// phase starts and matched by a monitor when the pulse appears.
module tb_wash_phase_timer;

    logic       clk;
    logic       rst;
    logic       i_CntEN;
    logic [1:0] i_CntNUM;
    logic       o_cntPulse;
    logic       o_busy;
    logic [7:0] o_remaining;

    typedef struct {
        string tag;
        int    rise;
        int    width;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rise_c   = 0;
    logic prev_p   = 1'b0;
    int   s, s2;

    wash_phase_timer #(
        .CNT_W      (8),
        .T_SOAK     (60),
        .T_MID      (120),
        .T_WASH     (180),
        .PULSE_WIDTH(10),
        .PW_W       (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_CntEN    (i_CntEN),
        .i_CntNUM   (i_CntNUM),
        .o_cntPulse (o_cntPulse),
        .o_busy     (o_busy),
        .o_remaining(o_remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_pulse(input string tag, input int rise, input int width);
        exp_t e;
        e.tag   = tag;
        e.rise  = rise;
        e.width = width;
        sb.push_back(e);
    endtask

    // Cycle index k at a negedge means edge k has just happened.
    always @(negedge clk) begin
        if (o_cntPulse === 1'b1 && prev_p === 1'b0) begin
            chk("pulse_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                chk({cur.tag, "_rise"}, cyc, cur.rise);
            end
            rise_c = cyc;
        end
        if (o_cntPulse === 1'b0 && prev_p === 1'b1) begin
            chk({cur.tag, "_width"}, cyc - rise_c, cur.width);
            chk({cur.tag, "_busy_at_fall"}, o_busy, 0);
        end
        prev_p = o_cntPulse;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        i_CntEN  = 1'b0;
        i_CntNUM = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_pulse", o_cntPulse, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_remaining", o_remaining, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("release_busy", o_busy, 0);
        chk("release_remaining", o_remaining, 0);

        // T1: reset in the middle of a count
        @(negedge clk);
        i_CntEN = 1'b1; i_CntNUM = 2'b01; s = cyc + 1;
        wait_until(s + 5);
        chk("t1_remaining", o_remaining, 55);
        chk("t1_busy", o_busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_pulse", o_cntPulse, 0);
        chk("t1_async_busy", o_busy, 0);
        chk("t1_async_remaining", o_remaining, 0);
        i_CntEN = 1'b0; i_CntNUM = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t1_idle_after", o_busy, 0);

        // T2: soak phase, enable held through the count
        @(negedge clk);
        i_CntEN = 1'b1; i_CntNUM = 2'b01; s = cyc + 1;
        expect_pulse("t2_soak", s + 60, 10);
        wait_until(s + 10);
        chk("t2_remaining_10", o_remaining, 50);
        wait_until(s + 59);
        chk("t2_remaining_last", o_remaining, 1);
        chk("t2_no_pulse_yet", o_cntPulse, 0);
        wait_until(s + 62);
        i_CntEN = 1'b0;
        wait_until(s + 69);
        chk("t2_last_pulse", o_cntPulse, 1);
        chk("t2_remaining_pulse", o_remaining, 0);
        wait_until(s + 70);
        chk("t2_busy_end", o_busy, 0);

        // T3: wash phase, select changed mid-count
        @(negedge clk);
        i_CntEN = 1'b1; i_CntNUM = 2'b11; s = cyc + 1;
        expect_pulse("t3_wash", s + 180, 10);
        wait_until(s + 50);
        i_CntNUM = 2'b01;
        wait_until(s + 100);
        chk("t3_remaining_100", o_remaining, 80);
        wait_until(s + 182);
        i_CntEN = 1'b0;
        wait_until(s + 190);
        chk("t3_busy_end", o_busy, 0);

        // T4: lid pause of 25 cycles with 30 cycles left
        @(negedge clk);
        i_CntEN = 1'b1; i_CntNUM = 2'b01; s = cyc + 1;
        expect_pulse("t4_pause", s + 85, 10);
        wait_until(s + 30);
        chk("t4_remaining_drop", o_remaining, 30);
        i_CntEN = 1'b0;
        wait_until(s + 45);
        chk("t4_remaining_hold", o_remaining, 30);
        chk("t4_busy_paused", o_busy, 1);
        wait_until(s + 55);
        i_CntEN = 1'b1;
        wait_until(s + 56);
        chk("t4_remaining_resume", o_remaining, 29);
        wait_until(s + 86);
        i_CntEN = 1'b0;
        wait_until(s + 95);
        chk("t4_busy_end", o_busy, 0);

        // T5: enable dropped on the third pulse cycle
        @(negedge clk);
        i_CntEN = 1'b1; i_CntNUM = 2'b01; s = cyc + 1;
        expect_pulse("t5_endrop", s + 60, 10);
        wait_until(s + 62);
        chk("t5_pulse_3rd", o_cntPulse, 1);
        i_CntEN = 1'b0;
        wait_until(s + 66);
        chk("t5_pulse_held", o_cntPulse, 1);
        wait_until(s + 70);
        chk("t5_busy_end", o_busy, 0);

        // T6: no-phase select, then back-to-back phases
        @(negedge clk);
        i_CntEN = 1'b1; i_CntNUM = 2'b00;
        repeat (5) @(negedge clk);
        chk("t6_none_busy", o_busy, 0);
        chk("t6_none_remaining", o_remaining, 0);
        i_CntNUM = 2'b01; s = cyc + 1;
        s2 = s + 71;
        expect_pulse("t6_first", s + 60, 10);
        expect_pulse("t6_second", s2 + 60, 10);
        wait_until(s + 70);
        chk("t6_gap_busy", o_busy, 0);
        wait_until(s + 71);
        chk("t6_second_busy", o_busy, 1);
        chk("t6_second_remaining", o_remaining, 60);
        wait_until(s2 + 62);
        i_CntEN = 1'b0;
        wait_until(s2 + 70);
        chk("t6_busy_end", o_busy, 0);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
